// File: rtl/cdc_bus_capture.sv
// Captures a data word into the local clock domain when a synchronized request
// transition arrives, then holds it for a fixed window and flags dropped requests.
module cdc_bus_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 3,
    parameter int EDGE_MODE   = 0,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             Aclk,
    input  logic             reset,
    input  logic             req_async,
    input  logic [WIDTH-1:0] din,
    input  logic             src_sel,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             ack_toggle,
    output logic             overrun,
    output logic [7:0]       capture_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;
    logic                   req_event;
    logic                   drop;
    logic [WIDTH-1:0]       pat_cnt;
    logic [3:0]             hold_cnt;
    state_t                 state;
    state_t                 state_nxt;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign req_event = (EDGE_MODE == 0) ? (sync_out ^ hist_q) : (sync_out & ~hist_q);

    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
            hist_q <= sync_out;
        end
    end

    // Free-running test pattern, selectable as the capture source.
    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            pat_cnt <= '0;
        end else begin
            pat_cnt <= pat_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (req_event) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
                drop      = req_event;
            end
            HOLD: begin
                drop = req_event;
                if (hold_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 4'd0;
        end else if (state == CAPTURE) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == HOLD) && (hold_cnt != 4'd0)) begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    // The capture side effects land on the edge that ends the CAPTURE cycle.
    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            dout        <= '0;
            dout_valid  <= 1'b0;
            ack_toggle  <= 1'b0;
            capture_cnt <= 8'd0;
        end else begin
            dout_valid <= (state == CAPTURE);
            if (state == CAPTURE) begin
                dout        <= src_sel ? pat_cnt : din;
                ack_toggle  <= ~ack_toggle;
                capture_cnt <= capture_cnt + 8'd1;
            end
        end
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge Aclk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/cdc_bus_capture.md
CDC_BUS_CAPTURE -- requirements
Module: cdc_bus_capture

Interface
REQ-001 Parameter WIDTH, default 8: data bus width; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 3: synchronizer flop count on req_async; legal range 2..4.
REQ-003 Parameter EDGE_MODE, default 0: 0 = capture on any req transition (toggle protocol); 1 = capture on rising transition only.
REQ-004 Parameter HOLD_CYCLES, default 4: minimum Aclk cycles dout stays frozen after a capture; legal range 1..15.
REQ-005 Aclk  input  1  sole clock; all flops rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_async  input  1  capture request from a foreign domain; asynchronous to Aclk.
REQ-008 din  input  WIDTH  external data; quasi-static while req_async settles.
REQ-009 src_sel  input  1  0 = capture din; 1 = capture internal pattern counter.
REQ-010 clr_overrun  input  1  synchronous clear of overrun.
REQ-011 dout  output  WIDTH  captured data, held between captures.
REQ-012 dout_valid  output  1  one-cycle pulse on each capture.
REQ-013 ack_toggle  output  1  inverts once per accepted capture; returned to the request domain.
REQ-014 overrun  output  1  sticky; a request was dropped.
REQ-015 capture_cnt  output  8  accepted-capture count.

Function
REQ-016 req_async SHALL pass through a chain of SYNC_STAGES flops, followed by one history flop; an event is "sync_out != history" (EDGE_MODE 0) or "sync_out & ~history" (EDGE_MODE 1).
REQ-017 Internal pattern counter: WIDTH bits, +1 every Aclk, wraps all-ones to zero; LSB toggles every cycle.
REQ-018 FSM states: IDLE, CAPTURE, HOLD.
REQ-019 IDLE: on event, go to CAPTURE; otherwise stay.
REQ-020 CAPTURE: lasts exactly one cycle; goes to HOLD.
REQ-021 On the CAPTURE edge: dout loads din or the pattern counter per src_sel, as sampled that cycle.
REQ-022 Also in CAPTURE: dout_valid = 1 for that cycle only; ack_toggle inverts; capture_cnt increments, wrapping 255 to 0.
REQ-023 HOLD lasts HOLD_CYCLES cycles via a down-counter, then returns to IDLE.
REQ-024 Any event detected in CAPTURE or HOLD, including the final HOLD cycle, SHALL be dropped and SHALL set overrun; it is never queued.
REQ-025 dout SHALL recirculate (hold its value) in every state except CAPTURE.
REQ-026 Latency: if the first Aclk edge that samples a new req_async level is edge 0, dout_valid is high in the cycle after edge SYNC_STAGES+1.
REQ-027 overrun SHALL be cleared by clr_overrun = 1; if a drop and clr_overrun coincide, set wins.
REQ-028 src_sel changes take effect only at the next CAPTURE.

Reset
REQ-029 While reset = 0, asynchronously: all sync and history flops = 0; FSM = IDLE; dout = 0.
REQ-030 Also under reset: dout_valid = 0; ack_toggle = 0; overrun = 0; capture_cnt = 0; pattern counter = 0; hold counter = 0.
REQ-031 Reset asserted mid-CAPTURE or mid-HOLD SHALL abort immediately, with no partial update.
REQ-032 After deassertion, req_async already high SHALL produce one event in EDGE_MODE 0 and EDGE_MODE 1.

Verification
REQ-033 SYNC_STAGES = 3, din = 8'hA5, src_sel = 0; req_async 0 to 1 -> dout = 8'hA5, dout_valid pulse 5 edges later, ack_toggle = 1, capture_cnt = 1.
REQ-034 EDGE_MODE 1; req_async 1 to 0 -> no dout_valid, dout unchanged; next 0 to 1 -> capture.
REQ-035 Second req_async toggle 2 cycles after first capture (HOLD_CYCLES = 4) -> dropped, overrun = 1, dout unchanged; clr_overrun pulse -> overrun = 0.
REQ-036 src_sel = 1, WIDTH = 4 -> captured values follow the pattern counter, including the wrap 4'hF to 4'h0; 256 captures -> capture_cnt wraps to 0.
REQ-037 reset pulsed low during HOLD -> all outputs 0 within the same cycle; FSM in IDLE after release.
